// File: rtl/vga_stream_decoder.sv
// Sink side of a VGA timing stream: recovers pixel coordinates by counting,
// verifies line/frame structure and tags each active pixel with its (x, y).
module vga_stream_decoder #(
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int WIDTH_BITS  = 10,
    parameter int HEIGHT_BITS = 10,
    parameter int PIXEL_BITS  = 12
) (
    input  logic                   clock_in,
    input  logic                   reset_n_in,
    input  logic                   h_sync_in,
    input  logic                   v_sync_in,
    input  logic                   display_on_in,
    input  logic [PIXEL_BITS-1:0]  pixel_in,
    output logic [WIDTH_BITS-1:0]  pixel_x_out,
    output logic [HEIGHT_BITS-1:0] pixel_y_out,
    output logic [PIXEL_BITS-1:0]  pixel_out,
    output logic                   pixel_valid_out,
    output logic                   locked_out,
    output logic                   frame_done_out,
    output logic                   error_out
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        SYNCING  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    localparam logic [WIDTH_BITS-1:0]  W_L   = WIDTH_BITS'(WIDTH);
    localparam logic [HEIGHT_BITS-1:0] H_L   = HEIGHT_BITS'(HEIGHT);
    localparam logic [WIDTH_BITS-1:0]  X_ONE = WIDTH_BITS'(1);
    localparam logic [HEIGHT_BITS-1:0] Y_ONE = HEIGHT_BITS'(1);

    state_t state, state_next;

    logic                   h_a, v_a, de_a;
    logic                   h_b, v_b, de_b;
    logic [PIXEL_BITS-1:0]  pix_a;
    logic [WIDTH_BITS-1:0]  x_cnt, x_cur, x_next;
    logic [HEIGHT_BITS-1:0] y_cnt, y_cur, y_next;
    logic                   frame_bad, frame_bad_next;
    logic                   run_seen, run_seen_next;
    logic                   h_edge, v_edge, de_rise, de_fall;
    logic                   run_over, line_over, frame_good;
    logic                   done_next, error_next, valid_next;

    // Stage A samples plus one cycle of history for edge detection.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            h_a   <= 1'b1;
            v_a   <= 1'b1;
            de_a  <= 1'b0;
            pix_a <= '0;
            h_b   <= 1'b1;
            v_b   <= 1'b1;
            de_b  <= 1'b0;
        end else begin
            h_a   <= h_sync_in;
            v_a   <= v_sync_in;
            de_a  <= display_on_in;
            pix_a <= pixel_in;
            h_b   <= h_a;
            v_b   <= v_a;
            de_b  <= de_a;
        end
    end

    assign h_edge  = h_b & ~h_a;
    assign v_edge  = v_b & ~v_a;
    assign de_rise = de_a & ~de_b;
    assign de_fall = de_b & ~de_a;

    // Coordinates seen by this cycle's pixel; a v_sync edge wins over h_sync.
    assign x_cur = (h_edge || v_edge) ? '0 : x_cnt;
    assign y_cur = v_edge ? '0 : y_cnt;

    always_comb begin
        x_next         = x_cur;
        y_next         = y_cur;
        frame_bad_next = v_edge ? 1'b0 : frame_bad;
        run_seen_next  = (h_edge || v_edge) ? 1'b0 : run_seen;
        run_over       = 1'b0;
        line_over      = 1'b0;
        if (de_a) begin
            if (de_rise && run_seen_next) begin
                frame_bad_next = 1'b1;
            end
            if (x_cur == W_L) begin
                run_over = 1'b1;
            end
            if (x_cur != '1) begin
                x_next = x_cur + X_ONE;
            end
        end else if (de_fall && !v_edge) begin
            if (x_cnt != W_L) begin
                frame_bad_next = 1'b1;
            end
            if (y_cur == H_L) begin
                line_over = 1'b1;
            end
            x_next        = '0;
            run_seen_next = 1'b1;
            if (y_cur != '1) begin
                y_next = y_cur + Y_ONE;
            end
        end
        if (run_over || line_over) begin
            frame_bad_next = 1'b1;
        end
    end

    assign frame_good = (y_cnt == H_L) && !frame_bad;
    assign valid_next = (state == LOCKED) && de_a && (x_cur < W_L) && (y_cur < H_L);

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        error_next = 1'b0;
        case (state)
            UNLOCKED: begin
                if (v_edge) begin
                    state_next = SYNCING;
                end
            end
            SYNCING: begin
                if (v_edge && frame_good) begin
                    state_next = LOCKED;
                    done_next  = 1'b1;
                end
            end
            LOCKED: begin
                if (v_edge) begin
                    if (frame_good) begin
                        done_next = 1'b1;
                    end else begin
                        error_next = 1'b1;
                        state_next = SYNCING;
                    end
                end else if (run_over || line_over) begin
                    // Report at once; SYNCING stays silent for the rest of the frame.
                    error_next = 1'b1;
                    state_next = SYNCING;
                end
            end
            default: state_next = UNLOCKED;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state           <= UNLOCKED;
            x_cnt           <= '0;
            y_cnt           <= '0;
            frame_bad       <= 1'b0;
            run_seen        <= 1'b0;
            pixel_x_out     <= '0;
            pixel_y_out     <= '0;
            pixel_out       <= '0;
            pixel_valid_out <= 1'b0;
            locked_out      <= 1'b0;
            frame_done_out  <= 1'b0;
            error_out       <= 1'b0;
        end else begin
            state           <= state_next;
            x_cnt           <= x_next;
            y_cnt           <= y_next;
            frame_bad       <= frame_bad_next;
            run_seen        <= run_seen_next;
            pixel_x_out     <= x_cur;
            pixel_y_out     <= y_cur;
            pixel_out       <= pix_a;
            pixel_valid_out <= valid_next;
            locked_out      <= (state_next == LOCKED);
            frame_done_out  <= done_next;
            error_out       <= error_next;
        end
    end

endmodule

// File: tb/tb_vga_stream_decoder.sv
// Bench for vga_stream_decoder: frame-level stream generator with a scoreboard
// of expected tagged pixels, frame/error pulses and lock transitions.
module tb_vga_stream_decoder;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int WB = 6;
    localparam int HB = 5;
    localparam int PB = 12;
    localparam int EW = 32 + WB + HB + PB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          h_sync, v_sync, display_on;
    logic [PB-1:0] pixel;
    logic [WB-1:0] pixel_x;
    logic [HB-1:0] pixel_y;
    logic [PB-1:0] pixel_o;
    logic          pixel_valid, locked, frame_done, error_p;

    vga_stream_decoder #(
        .WIDTH(W), .HEIGHT(H), .WIDTH_BITS(WB), .HEIGHT_BITS(HB), .PIXEL_BITS(PB)
    ) dut (
        .clock_in        (clk),
        .reset_n_in      (rst_n),
        .h_sync_in       (h_sync),
        .v_sync_in       (v_sync),
        .display_on_in   (display_on),
        .pixel_in        (pixel),
        .pixel_x_out     (pixel_x),
        .pixel_y_out     (pixel_y),
        .pixel_out       (pixel_o),
        .pixel_valid_out (pixel_valid),
        .locked_out      (locked),
        .frame_done_out  (frame_done),
        .error_out       (error_p)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];   // {cycle, x, y, pixel}
    logic [32:0]   evt_q[$];   // {cycle, is_error}
    logic [32:0]   lock_q[$];  // {cycle, locked value}
    int m_state = 0;           // 0 unlocked, 1 syncing, 2 locked
    bit f_good;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_x"},     64'(pixel_x), 64'd0);
        check({tag, "_y"},     64'(pixel_y), 64'd0);
        check({tag, "_pixel"}, 64'(pixel_o), 64'd0);
        check({tag, "_valid"}, 64'(pixel_valid), 64'd0);
        check({tag, "_locked"}, 64'(locked), 64'd0);
        check({tag, "_done"},  64'(frame_done), 64'd0);
        check({tag, "_error"}, 64'(error_p), 64'd0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic          exp_lock;
        logic          prev_lock;
        logic [EW-1:0] e;
        logic [32:0]   ev;
        bit            chg;
        exp_lock  = 1'b0;
        prev_lock = 1'b0;
        forever begin
            @(negedge clk);
            chg = (locked !== prev_lock);
            while (lock_q.size() > 0 && lock_q[0][32:1] <= cyc) begin
                if (lock_q[0][0] != exp_lock) chg = 1'b1;
                exp_lock = lock_q[0][0];
                void'(lock_q.pop_front());
            end
            prev_lock = locked;
            if (chg) check("locked_out", 64'(locked), 64'(exp_lock));

            if (pixel_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 64'({pixel_x, pixel_y, pixel_o}), 64'd0 - 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel{cyc,x,y,pix}", 64'({cyc, pixel_x, pixel_y, pixel_o}), 64'(e));
                end
            end
            while (exp_q.size() > 0 && exp_q[0][EW-1 -: 32] < cyc) begin
                check("missed_pixel_at", 64'(cyc), 64'(exp_q[0][EW-1 -: 32]));
                void'(exp_q.pop_front());
            end

            if (frame_done || error_p) begin
                if (evt_q.size() == 0) begin
                    check("unexpected_event{err,done}", 64'({error_p, frame_done}), 64'd0);
                end else begin
                    ev = evt_q.pop_front();
                    check("event{cyc,err,done}", 64'({cyc, error_p, frame_done}),
                          64'({ev[32:1], ev[0], ~ev[0]}));
                end
            end
            while (evt_q.size() > 0 && evt_q[0][32:1] < cyc) begin
                check("missed_event_at", 64'(cyc), 64'(evt_q[0][32:1]));
                void'(evt_q.pop_front());
            end
        end
    end

    // ---------------- reference model helpers ----------------
    task automatic push_evt(input logic err);
        evt_q.push_back({cyc + 32'd2, err});
    endtask

    task automatic push_lock(input logic val, input int unsigned dly);
        lock_q.push_back({cyc + dly, val});
    endtask

    // Frame verdict taken at the v_sync assertion.
    task automatic frame_eval();
        case (m_state)
            0: m_state = 1;
            1: if (f_good) begin
                   m_state = 2;
                   push_evt(1'b0);
                   push_lock(1'b1, 2);
               end
            default: if (f_good) begin
                   push_evt(1'b0);
               end else begin
                   push_evt(1'b1);
                   m_state = 1;
                   push_lock(1'b0, 2);
               end
        endcase
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic h, input logic v, input logic de, input logic [PB-1:0] p);
        @(posedge clk);
        #1;
        h_sync     = h;
        v_sync     = v;
        display_on = de;
        pixel      = p;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_frame");
        exp_q.delete();
        evt_q.delete();
        lock_q.delete();
        push_lock(1'b0, 0);
        m_state = 0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // mode 0: v high, 1: v falls at line start, 2: v falls with h_sync, 3: v held low
    task automatic blank_line(input int mode);
        logic h, v;
        for (int i = 0; i < W + 7; i++) begin
            h = !(i >= W + 2 && i < W + 5);
            v = (mode == 0) ? 1'b1 : (mode == 2) ? (i < W + 2) : 1'b0;
            step(h, v, 1'b0, '0);
            if ((mode == 1 && i == 0) || (mode == 2 && i == W + 2)) frame_eval();
        end
    endtask

    task automatic drive_frame(input int nlines, input int runs[8], input bit ramp,
                               input bit simul, input int rst_line);
        int            imm_l;
        bit            imm_over;
        bit            lk;
        logic [PB-1:0] p;
        logic [WB-1:0] xb;
        logic [HB-1:0] yb;
        f_good   = (nlines == H);
        imm_l    = -1;
        imm_over = 1'b0;
        for (int l = 0; l < nlines; l++) begin
            if (runs[l] != W) f_good = 1'b0;
            if (imm_l < 0 && runs[l] > W) begin imm_l = l; imm_over = 1'b1; end
            else if (imm_l < 0 && l == H) begin imm_l = l; imm_over = 1'b0; end
        end
        lk = (m_state == 2);
        for (int l = 0; l < nlines; l++) begin
            for (int c = 0; c < runs[l]; c++) begin
                p = ramp ? c[PB-1:0] : PB'($urandom);
                step(1'b1, 1'b1, 1'b1, p);
                if (lk && c < W && l < H) begin
                    xb = c[WB-1:0];
                    yb = l[HB-1:0];
                    exp_q.push_back({cyc + 32'd2, xb, yb, p});
                end
                if (lk && imm_over && l == imm_l && c == W) begin
                    push_evt(1'b1);
                    push_lock(1'b0, 2);
                    m_state = 1;
                    lk = 1'b0;
                end
                if (l == rst_line && c == 2) begin
                    do_reset();
                    lk = 1'b0;
                end
            end
            step(1'b1, 1'b1, 1'b0, '0);
            if (lk && !imm_over && l == imm_l) begin
                push_evt(1'b1);
                push_lock(1'b0, 2);
                m_state = 1;
                lk = 1'b0;
            end
            step(1'b1, 1'b1, 1'b0, '0);
            repeat (3) step(1'b0, 1'b1, 1'b0, '0);
            repeat (2) step(1'b1, 1'b1, 1'b0, '0);
        end
        blank_line(0);
        blank_line(simul ? 2 : 1);
        blank_line(3);
        blank_line(0);
    endtask

    task automatic clean_frames(input int n);
        int r[8];
        for (int i = 0; i < 8; i++) r[i] = W;
        for (int k = 0; k < n; k++) drive_frame(H, r, 1'b0, 1'b0, -1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r[8];
        int nl;
        int pick;
        rst_n      = 1'b0;
        h_sync     = 1'b1;
        v_sync     = 1'b1;
        display_on = 1'b0;
        pixel      = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        #2;
        rst_n = 1'b1;

        // Power-up: SYNCING after first edge, LOCKED at the second, pixels in frame 3.
        clean_frames(3);

        // Short line while locked: error at the next v_sync edge, then relock.
        for (int i = 0; i < 8; i++) r[i] = W;
        r[1] = W - 1;
        drive_frame(H, r, 1'b0, 1'b0, -1);
        clean_frames(2);

        // One line too many: immediate error at end of the extra line.
        for (int i = 0; i < 8; i++) r[i] = W;
        drive_frame(H + 1, r, 1'b0, 1'b0, -1);
        clean_frames(2);

        // Column ramp on the pixel data.
        drive_frame(H, r, 1'b1, 1'b0, -1);

        // Over-long run: immediate error.
        r[2] = W + 1;
        drive_frame(H, r, 1'b0, 1'b0, -1);
        clean_frames(2);

        // h_sync and v_sync asserted on the same clock.
        for (int i = 0; i < 8; i++) r[i] = W;
        drive_frame(H, r, 1'b0, 1'b1, -1);
        drive_frame(H, r, 1'b1, 1'b1, -1);

        // Reset in the middle of a locked frame.
        drive_frame(H, r, 1'b0, 1'b0, 2);
        clean_frames(3);

        // Randomised frames.
        for (int k = 0; k < 16; k++) begin
            pick = $urandom_range(0, 5);
            nl = (pick == 0) ? H - 1 : (pick == 1) ? H + 1 : H;
            for (int i = 0; i < 8; i++) begin
                pick = $urandom_range(0, 11);
                r[i] = (pick == 0) ? W - 1 : (pick == 1) ? W + 1 : W;
            end
            drive_frame(nl, r, 1'b0, 1'($urandom_range(0, 1)), -1);
        end
        clean_frames(2);

        repeat (6) step(1'b1, 1'b1, 1'b0, '0);
        check("pixels_left", 64'(exp_q.size()), 64'd0);
        check("events_left", 64'(evt_q.size()), 64'd0);
        check("final_locked", 64'(locked), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
